nv_nvdla_cmac_pdp: RTL and testbench
====================================

NV_NVDLA_CMAC_PDP -- requirements
Module: nv_nvdla_cmac_pdp

Interface
REQ-001 Parameter ATOMC, default 8, number of input channel lanes per atom (even, >=2).
REQ-002 Parameter ATOMK_HALF, default 4, number of kernels computed in parallel.
REQ-003 Parameter BPE, default 8, bits per lane element.
REQ-004 Parameter RESULT_WIDTH, default 4*BPE+clog2(ATOMC), width of each per-kernel partial sum.
REQ-005 nvdla_core_clk  in  1  sole clock; every flop is rising-edge.
REQ-006 nvdla_core_rst  in  1  asynchronous, active-high reset.
REQ-007 reg2dp_op_en  in  1  layer enable; its rising edge starts a layer.
REQ-008 reg2dp_proc_precision  in  1  0=INT8 lanes, 1=INT16 lane pairs; sampled on the op_en rising edge.
REQ-009 sc2mac_wt_pvld  in  1  weight write strobe.
REQ-010 sc2mac_wt_mask  in  ATOMC  per-lane weight nonzero flags.
REQ-011 sc2mac_wt_data  in  ATOMC*BPE  weight lanes, lane i at [i*BPE +: BPE].
REQ-012 sc2mac_wt_sel  in  ATOMK_HALF  one-hot-or-more kernel select for the weight write.
REQ-013 sc2mac_dat_pvld  in  1  data atom strobe.
REQ-014 sc2mac_dat_mask  in  ATOMC  per-lane data nonzero flags.
REQ-015 sc2mac_dat_data  in  ATOMC*BPE  data lanes, same packing as weights.
REQ-016 sc2mac_dat_pd  in  9  sideband; bit 8 = layer_end.
REQ-017 mac2accu_pvld  out  1  result valid.
REQ-018 mac2accu_mask  out  ATOMK_HALF  per-kernel result-valid flags.
REQ-019 mac2accu_mode  out  1  precision in effect for this result.
REQ-020 mac2accu_data  out  ATOMK_HALF*RESULT_WIDTH  signed partial sums, kernel k at [k*RESULT_WIDTH +: RESULT_WIDTH].
REQ-021 mac2accu_pd  out  9  sc2mac_dat_pd delayed with its data.
REQ-022 dp2reg_done  out  1  single-cycle layer-complete pulse.

Function
REQ-023 Weight write: on wt_pvld, every kernel k with wt_sel[k]=1 SHALL store wt_data/wt_mask into its weight register and set wt_vld[k]; a same-cycle data atom SHALL use the pre-write weights.
REQ-024 wt_vld[] SHALL clear on the op_en rising edge; a weight write in that same cycle SHALL win and set its bits.
REQ-025 INT8: lane i contributes signed(dat_i)*signed(wt_i) iff dat_mask[i] and wt_mask[i]; otherwise 0.
REQ-026 INT16: pair j (lanes 2j low byte, 2j+1 high byte) forms signed 2*BPE operands; contributes iff all four mask bits of the pair are 1.
REQ-027 Each kernel sum SHALL be sign-extended to RESULT_WIDTH with no saturation or truncation.
REQ-028 Pipeline: input register, product stage, adder-tree stage, output register; mac2accu_pvld SHALL follow dat_pvld by exactly 4 cycles, one result per accepted atom, no backpressure, no bubbles inserted.
REQ-029 mac2accu_mask SHALL equal wt_vld[] at atom acceptance; data for masked-off kernels SHALL be zero.
REQ-030 Atoms accepted while op_en=0 SHALL be dropped (no output).
REQ-031 dp2reg_done SHALL pulse in the cycle mac2accu_pvld=1 with mac2accu_pd[8]=1; back-to-back layer_end atoms give back-to-back pulses.
REQ-032 op_en falling mid-layer SHALL NOT flush atoms already in the pipeline.

Reset
REQ-033 On nvdla_core_rst: all valid bits, wt_vld[], mac2accu_pvld, mac2accu_mask, dp2reg_done SHALL be 0; mac2accu_data/pd/mode SHALL be 0; precision SHALL be INT8.
REQ-034 Reset asserted mid-pipeline SHALL discard all in-flight atoms; no output after deassertion until a new atom is accepted.
REQ-035 Weight data registers need no reset; only valid state is reset.

Structure
REQ-036 The precision encoding, pd bit index of layer_end and the pipeline depth constant SHALL live in shared package nv_nvdla_cmac_pkg.
REQ-037 One sub-module nv_nvdla_cmac_pdp_kernel (one kernel's multiply and adder tree) SHALL be instantiated ATOMK_HALF times.

Verification
REQ-038 INT8, kernel 0 weights all 1, data all 2, masks full -> mac2accu_data0=16, mask=0001, 4 cycles after dat_pvld.
REQ-039 INT8, dat_mask=0x0F, weights -3, data 5 -> kernel sum -60.
REQ-040 INT16, pair weights 0x0100 (256), data 0x00FF (255), 4 pairs -> 261120, mode=1.
REQ-041 Weight write and data in the same cycle -> result uses old weights; next atom uses new ones.
REQ-042 Three consecutive atoms, last with pd[8]=1 -> three pvld cycles, dp2reg_done only on the third.
REQ-043 Reset asserted with 2 atoms in flight -> no pvld after release, all outputs 0.

Source files
------------

// File: rtl/nv_nvdla_cmac_pkg.sv
// Shared definitions for the CMAC partial-dot-product datapath.
package nv_nvdla_cmac_pkg;

   typedef enum logic {
      PREC_INT8  = 1'b0,
      PREC_INT16 = 1'b1
   } prec_e;

   localparam int unsigned PD_W         = 9;
   localparam int unsigned PD_LAYER_END = 8;
   localparam int unsigned PIPE_DEPTH   = 4;

endpackage

// File: rtl/nv_nvdla_cmac_pdp_kernel.sv
// One kernel: masked lane products (stage 2) followed by an adder tree (stage 3).
module nv_nvdla_cmac_pdp_kernel
   import nv_nvdla_cmac_pkg::*;
#(
   parameter int unsigned ATOMC        = 8,
   parameter int unsigned BPE          = 8,
   parameter int unsigned RESULT_WIDTH = 4*BPE + $clog2(ATOMC)
) (
   input  logic                      clk,
   input  logic                      mode,
   input  logic [ATOMC*BPE-1:0]      dat,
   input  logic [ATOMC-1:0]          dat_mask,
   input  logic [ATOMC*BPE-1:0]      wt,
   input  logic [ATOMC-1:0]          wt_mask,
   output logic [RESULT_WIDTH-1:0]   sum
);

   localparam int unsigned W2    = 2*BPE;
   localparam int unsigned PW    = 4*BPE;
   localparam int unsigned PAIRS = ATOMC/2;

   logic [PW-1:0]           prod_c [ATOMC];
   logic [PW-1:0]           prod_q [ATOMC];
   logic [RESULT_WIDTH-1:0] sum_c;

   function automatic logic [PW-1:0] mul8(input logic [BPE-1:0] a, input logic [BPE-1:0] b);
      logic signed [W2-1:0] p;
      p = W2'($signed(a)) * W2'($signed(b));
      return {{(PW-W2){p[W2-1]}}, p};
   endfunction

   function automatic logic [PW-1:0] mul16(input logic [W2-1:0] a, input logic [W2-1:0] b);
      logic signed [PW-1:0] p;
      p = PW'($signed(a)) * PW'($signed(b));
      return p;
   endfunction

   // Lane products; INT16 pair results land in the even slot, odd slot stays zero.
   always_comb begin
      for (int i = 0; i < ATOMC; i++) prod_c[i] = '0;
      if (mode == PREC_INT16) begin
         for (int j = 0; j < PAIRS; j++) begin
            if (dat_mask[2*j] && dat_mask[2*j+1] && wt_mask[2*j] && wt_mask[2*j+1])
               prod_c[2*j] = mul16(dat[2*j*BPE +: W2], wt[2*j*BPE +: W2]);
         end
      end else begin
         for (int i = 0; i < ATOMC; i++) begin
            if (dat_mask[i] && wt_mask[i])
               prod_c[i] = mul8(dat[i*BPE +: BPE], wt[i*BPE +: BPE]);
         end
      end
   end

   // Sign-extended sum of all product slots.
   always_comb begin
      sum_c = '0;
      for (int i = 0; i < ATOMC; i++)
         sum_c = sum_c + {{(RESULT_WIDTH-PW){prod_q[i][PW-1]}}, prod_q[i]};
   end

   // Datapath stages carry no reset; validity is tracked by the parent.
   always_ff @(posedge clk) begin
      prod_q <= prod_c;
      sum    <= sum_c;
   end

endmodule

// File: rtl/nv_nvdla_cmac_pdp.sv
// CMAC partial dot product: weight store, 4-stage MAC pipeline, layer-done pulse.
module nv_nvdla_cmac_pdp
   import nv_nvdla_cmac_pkg::*;
#(
   parameter int unsigned ATOMC        = 8,
   parameter int unsigned ATOMK_HALF   = 4,
   parameter int unsigned BPE          = 8,
   parameter int unsigned RESULT_WIDTH = 4*BPE + $clog2(ATOMC)
) (
   input  logic                               nvdla_core_clk,
   input  logic                               nvdla_core_rst,
   input  logic                               reg2dp_op_en,
   input  logic                               reg2dp_proc_precision,
   input  logic                               sc2mac_wt_pvld,
   input  logic [ATOMC-1:0]                   sc2mac_wt_mask,
   input  logic [ATOMC*BPE-1:0]               sc2mac_wt_data,
   input  logic [ATOMK_HALF-1:0]              sc2mac_wt_sel,
   input  logic                               sc2mac_dat_pvld,
   input  logic [ATOMC-1:0]                   sc2mac_dat_mask,
   input  logic [ATOMC*BPE-1:0]               sc2mac_dat_data,
   input  logic [PD_W-1:0]                    sc2mac_dat_pd,
   output logic                               mac2accu_pvld,
   output logic [ATOMK_HALF-1:0]              mac2accu_mask,
   output logic                               mac2accu_mode,
   output logic [ATOMK_HALF*RESULT_WIDTH-1:0] mac2accu_data,
   output logic [PD_W-1:0]                    mac2accu_pd,
   output logic                               dp2reg_done
);

   localparam int unsigned DW = ATOMC*BPE;

   logic                  op_en_d;
   logic                  op_rise_c;
   logic                  accept_c;
   prec_e                 prec_q;
   prec_e                 atom_mode_c;
   logic [ATOMK_HALF-1:0] wt_vld;
   logic [ATOMK_HALF-1:0] wt_vld_nxt_c;
   logic [DW-1:0]         wt_data_q [ATOMK_HALF];
   logic [ATOMC-1:0]      wt_mask_q [ATOMK_HALF];

   logic                  s1_vld, s2_vld, s3_vld;
   logic [ATOMK_HALF-1:0] s1_mask, s2_mask, s3_mask;
   logic                  s1_mode, s2_mode, s3_mode;
   logic [PD_W-1:0]       s1_pd, s2_pd, s3_pd;
   logic [DW-1:0]         s1_dat;
   logic [ATOMC-1:0]      s1_dmask;
   logic [DW-1:0]         s1_wt [ATOMK_HALF];
   logic [ATOMC-1:0]      s1_wmask [ATOMK_HALF];
   logic [RESULT_WIDTH-1:0] ksum [ATOMK_HALF];

   assign op_rise_c   = reg2dp_op_en & ~op_en_d;
   assign accept_c    = sc2mac_dat_pvld & reg2dp_op_en;
   assign atom_mode_c = op_rise_c ? prec_e'(reg2dp_proc_precision) : prec_q;

   // Kernel valid flags: cleared at layer start, a same-cycle write still sets its bits.
   always_comb begin
      wt_vld_nxt_c = op_rise_c ? '0 : wt_vld;
      if (sc2mac_wt_pvld) wt_vld_nxt_c = wt_vld_nxt_c | sc2mac_wt_sel;
   end

   // Control state and sideband pipeline (valid, mask, mode, pd).
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         op_en_d <= 1'b0;
         prec_q  <= PREC_INT8;
         wt_vld  <= '0;
         s1_vld  <= 1'b0;
         s2_vld  <= 1'b0;
         s3_vld  <= 1'b0;
         s1_mask <= '0;
         s2_mask <= '0;
         s3_mask <= '0;
         s1_mode <= 1'b0;
         s2_mode <= 1'b0;
         s3_mode <= 1'b0;
         s1_pd   <= '0;
         s2_pd   <= '0;
         s3_pd   <= '0;
      end else begin
         op_en_d <= reg2dp_op_en;
         if (op_rise_c) prec_q <= prec_e'(reg2dp_proc_precision);
         wt_vld  <= wt_vld_nxt_c;
         s1_vld  <= accept_c;
         if (accept_c) begin
            s1_mask <= wt_vld;
            s1_mode <= atom_mode_c;
            s1_pd   <= sc2mac_dat_pd;
         end
         s2_vld  <= s1_vld;
         s2_mask <= s1_mask;
         s2_mode <= s1_mode;
         s2_pd   <= s1_pd;
         s3_vld  <= s2_vld;
         s3_mask <= s2_mask;
         s3_mode <= s2_mode;
         s3_pd   <= s2_pd;
      end
   end

   // Weight store and input register; the atom snapshots pre-write weights.
   always_ff @(posedge nvdla_core_clk) begin
      for (int k = 0; k < ATOMK_HALF; k++) begin
         if (sc2mac_wt_pvld && sc2mac_wt_sel[k]) begin
            wt_data_q[k] <= sc2mac_wt_data;
            wt_mask_q[k] <= sc2mac_wt_mask;
         end
      end
      if (accept_c) begin
         s1_dat   <= sc2mac_dat_data;
         s1_dmask <= sc2mac_dat_mask;
         s1_wt    <= wt_data_q;
         s1_wmask <= wt_mask_q;
      end
   end

   for (genvar k = 0; k < ATOMK_HALF; k++) begin : g_kernel
      nv_nvdla_cmac_pdp_kernel #(
         .ATOMC        (ATOMC),
         .BPE          (BPE),
         .RESULT_WIDTH (RESULT_WIDTH)
      ) u_kernel (
         .clk      (nvdla_core_clk),
         .mode     (s1_mode),
         .dat      (s1_dat),
         .dat_mask (s1_dmask),
         .wt       (s1_wt[k]),
         .wt_mask  (s1_wmask[k]),
         .sum      (ksum[k])
      );
   end

   // Output register; masked-off kernels report zero.
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         mac2accu_pvld <= 1'b0;
         mac2accu_mask <= '0;
         mac2accu_mode <= 1'b0;
         mac2accu_data <= '0;
         mac2accu_pd   <= '0;
         dp2reg_done   <= 1'b0;
      end else begin
         mac2accu_pvld <= s3_vld;
         dp2reg_done   <= s3_vld & s3_pd[PD_LAYER_END];
         if (s3_vld) begin
            mac2accu_mask <= s3_mask;
            mac2accu_mode <= s3_mode;
            mac2accu_pd   <= s3_pd;
            for (int k = 0; k < ATOMK_HALF; k++)
               mac2accu_data[k*RESULT_WIDTH +: RESULT_WIDTH] <= s3_mask[k] ? ksum[k] : '0;
         end
      end
   end

endmodule

// File: tb/tb_nv_nvdla_cmac_pdp.sv
// Self-checking bench for nv_nvdla_cmac_pdp: directed vectors, corner sequences, random vs model.
module tb_nv_nvdla_cmac_pdp;
   import nv_nvdla_cmac_pkg::*;

   localparam int unsigned ATOMC = 8;
   localparam int unsigned AK    = 4;
   localparam int unsigned BPE   = 8;
   localparam int unsigned RW    = 4*BPE + $clog2(ATOMC);
   localparam int unsigned DW    = ATOMC*BPE;
   localparam int unsigned OW    = AK*RW;

   logic              clk, rst;
   logic              op_en, prec;
   logic              wt_pvld;
   logic [ATOMC-1:0]  wt_mask;
   logic [DW-1:0]     wt_data;
   logic [AK-1:0]     wt_sel;
   logic              dat_pvld;
   logic [ATOMC-1:0]  dat_mask;
   logic [DW-1:0]     dat_data;
   logic [8:0]        dat_pd;
   logic              pvld;
   logic [AK-1:0]     omask;
   logic              omode;
   logic [OW-1:0]     odata;
   logic [8:0]        opd;
   logic              done;

   nv_nvdla_cmac_pdp #(.ATOMC(ATOMC), .ATOMK_HALF(AK), .BPE(BPE), .RESULT_WIDTH(RW)) dut (
      .nvdla_core_clk        (clk),
      .nvdla_core_rst        (rst),
      .reg2dp_op_en          (op_en),
      .reg2dp_proc_precision (prec),
      .sc2mac_wt_pvld        (wt_pvld),
      .sc2mac_wt_mask        (wt_mask),
      .sc2mac_wt_data        (wt_data),
      .sc2mac_wt_sel         (wt_sel),
      .sc2mac_dat_pvld       (dat_pvld),
      .sc2mac_dat_mask       (dat_mask),
      .sc2mac_dat_data       (dat_data),
      .sc2mac_dat_pd         (dat_pd),
      .mac2accu_pvld         (pvld),
      .mac2accu_mask         (omask),
      .mac2accu_mode         (omode),
      .mac2accu_data         (odata),
      .mac2accu_pd           (opd),
      .dp2reg_done           (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   typedef struct {
      int            due;
      logic [AK-1:0] mask;
      logic          mode;
      logic [OW-1:0] data;
      logic [8:0]    pd;
   } exp_t;

   typedef struct {
      logic             prec;
      logic [15:0]      w;
      logic [15:0]      d;
      logic [ATOMC-1:0] dm;
      longint           sum;
   } vec_t;

   exp_t             q[$];
   vec_t             vt[7];
   logic [DW-1:0]    m_wt[AK];
   logic [ATOMC-1:0] m_wm[AK];
   logic [AK-1:0]    m_vld;
   logic             m_prec;
   logic             m_prev;
   int               cyc;
   int               n_cmp;
   int               n_err;

   // Reference dot product straight from the lane/pair rules.
   function automatic longint kern_sum(input logic md, input logic [DW-1:0] d, input logic [ATOMC-1:0] dm,
                                       input logic [DW-1:0] w, input logic [ATOMC-1:0] wm);
      longint s;
      logic signed [BPE-1:0]   a8, b8;
      logic signed [2*BPE-1:0] a16, b16;
      s = 0;
      if (!md) begin
         for (int i = 0; i < ATOMC; i++) begin
            if (dm[i] && wm[i]) begin
               a8 = d[i*BPE +: BPE];
               b8 = w[i*BPE +: BPE];
               s += longint'(a8) * longint'(b8);
            end
         end
      end else begin
         for (int j = 0; j < ATOMC/2; j++) begin
            if (dm[2*j] && dm[2*j+1] && wm[2*j] && wm[2*j+1]) begin
               a16 = d[2*j*BPE +: 2*BPE];
               b16 = w[2*j*BPE +: 2*BPE];
               s += longint'(a16) * longint'(b16);
            end
         end
      end
      return s;
   endfunction

   task automatic chk(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Feed the inputs about to be sampled into the model.
   task automatic model_step();
      exp_t e;
      logic rise;
      rise = op_en && !m_prev;
      if (dat_pvld && op_en) begin
         e.due  = cyc + PIPE_DEPTH;
         e.mode = rise ? prec : m_prec;
         e.mask = m_vld;
         e.pd   = dat_pd;
         e.data = '0;
         for (int k = 0; k < AK; k++)
            if (m_vld[k]) e.data[k*RW +: RW] = RW'(kern_sum(e.mode, dat_data, dat_mask, m_wt[k], m_wm[k]));
         q.push_back(e);
      end
      if (rise) begin
         m_prec = prec;
         m_vld  = '0;
      end
      if (wt_pvld) begin
         for (int k = 0; k < AK; k++) begin
            if (wt_sel[k]) begin
               m_wt[k]  = wt_data;
               m_wm[k]  = wt_mask;
               m_vld[k] = 1'b1;
            end
         end
      end
      m_prev = op_en;
   endtask

   task automatic check_outputs();
      exp_t e;
      logic ev;
      ev = (q.size() > 0) && (q[0].due == cyc);
      chk("pvld", OW'(pvld), OW'(ev));
      if (ev) begin
         e = q.pop_front();
         chk("mask", OW'(omask), OW'(e.mask));
         chk("mode", OW'(omode), OW'(e.mode));
         chk("data", odata, e.data);
         chk("pd", OW'(opd), OW'(e.pd));
         chk("done", OW'(done), OW'(e.pd[8]));
      end else begin
         chk("done idle", OW'(done), '0);
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      check_outputs();
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " pvld"}, OW'(pvld), '0);
      chk({nm, " mask"}, OW'(omask), '0);
      chk({nm, " mode"}, OW'(omode), '0);
      chk({nm, " data"}, odata, '0);
      chk({nm, " pd"}, OW'(opd), '0);
      chk({nm, " done"}, OW'(done), '0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      q.delete();
      m_vld  = '0;
      m_prec = 1'b0;
      m_prev = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;
   endtask

   task automatic idle();
      wt_pvld  = 1'b0;
      dat_pvld = 1'b0;
      dat_pd   = '0;
   endtask

   function automatic logic [DW-1:0] pack(input logic p, input logic [15:0] v);
      logic [7:0] b;
      b = v[7:0];
      return p ? {(ATOMC/2){v}} : {ATOMC{b}};
   endfunction

   initial begin
      logic [RW-1:0] ev;
      int pv, dn, dcyc, start;

      vt[0] = '{1'b0, 16'h0001, 16'h0002, 8'hFF, 64'sd16};
      vt[1] = '{1'b0, 16'h00FD, 16'h0005, 8'h0F, -64'sd60};
      vt[2] = '{1'b1, 16'h0100, 16'h00FF, 8'hFF, 64'sd261120};
      vt[3] = '{1'b0, 16'h0080, 16'h0080, 8'hFF, 64'sd131072};
      vt[4] = '{1'b1, 16'h8000, 16'h8000, 8'hFF, 64'sd4294967296};
      vt[5] = '{1'b1, 16'h0100, 16'h00FF, 8'hF3, 64'sd195840};
      vt[6] = '{1'b1, 16'hFFFF, 16'h7FFF, 8'hFF, -64'sd131068};

      n_cmp = 0; n_err = 0; cyc = 0;
      rst = 1'b1; op_en = 1'b0; prec = 1'b0;
      wt_pvld = 1'b0; wt_mask = '0; wt_data = '0; wt_sel = '0;
      dat_pvld = 1'b0; dat_mask = '0; dat_data = '0; dat_pd = '0;
      do_reset();

      // Directed table: kernel 0 loaded at layer start, one atom, 4-cycle latency.
      for (int i = 0; i < 7; i++) begin
         idle(); op_en = 1'b0; tick();
         op_en = 1'b1; prec = vt[i].prec;
         wt_pvld = 1'b1; wt_sel = 4'b0001; wt_mask = '1; wt_data = pack(vt[i].prec, vt[i].w);
         tick();
         wt_pvld = 1'b0; dat_pvld = 1'b1; dat_mask = vt[i].dm; dat_data = pack(vt[i].prec, vt[i].d);
         tick();
         dat_pvld = 1'b0;
         repeat (3) tick();
         ev = RW'(vt[i].sum);
         chk("vec pvld", OW'(pvld), OW'(1'b1));
         chk("vec sum0", OW'(odata[RW-1:0]), OW'(ev));
         chk("vec mask", OW'(omask), OW'(4'b0001));
         chk("vec mode", OW'(omode), OW'(vt[i].prec));
         chk("vec others", OW'(odata[OW-1:RW]), '0);
      end

      // Weight write alongside an atom: that atom sees old weights, the next sees new.
      idle(); op_en = 1'b0; prec = 1'b0; tick();
      op_en = 1'b1; wt_pvld = 1'b1; wt_sel = 4'b0001; wt_mask = '1; wt_data = pack(1'b0, 16'h0001);
      tick();
      wt_data = pack(1'b0, 16'h0002);
      dat_pvld = 1'b1; dat_mask = '1; dat_data = pack(1'b0, 16'h0001);
      tick();
      wt_pvld = 1'b0;
      tick();
      dat_pvld = 1'b0;
      repeat (2) tick();
      chk("wsame old", OW'(odata[RW-1:0]), OW'(RW'(8)));
      tick();
      chk("wsame new", OW'(odata[RW-1:0]), OW'(RW'(16)));

      // Three consecutive atoms, only the last closes the layer.
      start = cyc;
      dat_pvld = 1'b1; dat_mask = '1;
      for (int a = 0; a < 3; a++) begin
         dat_data = {$urandom, $urandom};
         dat_pd = {(a == 2), 8'(a)};
         tick();
      end
      idle();
      pv = 0; dn = 0; dcyc = -1;
      repeat (6) begin
         tick();
         if (pvld) pv++;
         if (done) begin dn++; dcyc = cyc; end
      end
      chk("layer pvld count", OW'(pv), OW'(3));
      chk("layer done count", OW'(dn), OW'(1));
      chk("layer done cycle", OW'(dcyc), OW'(start + 6));

      // Reset with two atoms in flight.
      dat_pvld = 1'b1; dat_data = {$urandom, $urandom}; dat_pd = 9'h100;
      tick(); tick();
      idle();
      tick();
      do_reset();
      pv = 0;
      repeat (6) begin
         tick();
         if (pvld) pv++;
      end
      chk("post reset pvld count", OW'(pv), '0);
      chk_zero("post reset");

      // Randomized traffic against the model.
      op_en = 1'b1;
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 15) == 0) op_en = ~op_en;
         prec     = 1'($urandom);
         wt_pvld  = ($urandom_range(0, 3) == 0);
         wt_sel   = AK'($urandom);
         wt_mask  = ($urandom_range(0, 3) == 0) ? ATOMC'($urandom) : '1;
         wt_data  = {$urandom, $urandom};
         dat_pvld = ($urandom_range(0, 3) != 0);
         dat_mask = ($urandom_range(0, 3) == 0) ? ATOMC'($urandom) : '1;
         dat_data = {$urandom, $urandom};
         dat_pd   = {($urandom_range(0, 5) == 0), 8'($urandom)};
         tick();
      end
      idle();
      repeat (6) tick();
      chk("drain queue empty", OW'(q.size()), '0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
